overture_run_ctrl: RTL and testbench
====================================

# overture_run_ctrl

Execution controller for `overture_cpu`: owns the CPU's `run` and `reset` inputs and sequences execution from a simple command interface. Supports free-run, single-step, run-for-N cycles, stop, and one PC breakpoint. Also reports executed-cycle count and flags changes on the CPU output port. It sits between the host/testbench command source and the CPU program wrappers; the wrapper's `pc`/`out_port` feed back into it.

## Interface
- `CYCLE_W`, 16, width of `cmd_arg` and `cycle_count`
- `RESET_CYCLES`, 2, cycles `cpu_reset` is held per reset sequence (≥1)

- `clk` in 1: sole clock
- `reset` in 1: synchronous, active-high
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at a rising edge
- `cmd_op` in 3: 0 NOP, 1 RESET, 2 RUN, 3 STEP, 4 RUN_N, 5 STOP, 6 SET_BP
- `cmd_arg` in CYCLE_W: RUN_N count; SET_BP uses [7:0] address, [8] enable
- `pc` in 8: CPU program counter
- `out_port` in 8: CPU output port
- `cpu_reset` out 1: drives CPU `reset`
- `cpu_run` out 1: drives CPU `run`; CPU advances one instruction per edge while high
- `state` out 2: 0 CPU_RST, 1 HALTED, 2 RUNNING
- `halt_cause` out 2: 0 NONE, 1 STOP, 2 BP, 3 DONE
- `cycle_count` out CYCLE_W: edges with `cpu_run` high since last RESET; wraps
- `out_valid` out 1: one-cycle pulse, `out_port` changed
- `out_data` out 8: new `out_port` value accompanying `out_valid`

## Operation
- States CPU_RST, HALTED, RUNNING. Reset → CPU_RST, rst counter = RESET_CYCLES, cause NONE, cycle_count 0, bp disabled (addr 0), `out_valid` 0, `out_data` 0, previous-out sample 0.
- `cpu_reset` = `reset` OR (state==CPU_RST). CPU_RST decrements counter each cycle; at 1 → HALTED. `cmd_ready` = 0 in CPU_RST, 1 otherwise.
- HALTED commands: NOP no effect; RESET → CPU_RST, counter reload, cycle_count cleared, cause NONE; RUN → RUNNING, remaining = unbounded; STEP → RUNNING, remaining = 1; RUN_N → RUNNING, remaining = arg, except arg==0 → stays HALTED, cause DONE; STOP → cause STOP, no state change; SET_BP → latch addr/enable.
- RUNNING commands: STOP → HALTED, cause STOP (the cycle it is accepted still has `cpu_run` per rules below); RESET as in HALTED; SET_BP latched; RUN/STEP/RUN_N/NOP ignored.
- `cpu_run` (combinational from registered state) = RUNNING AND NOT bp_hit, where bp_hit = bp_en AND pc==bp_addr AND NOT first_cycle. first_cycle is set on entering RUNNING and cleared after one RUNNING cycle, so a run resumed from the breakpoint PC executes it.
- In RUNNING: if bp_hit → HALTED, cause BP (instruction at bp_addr not executed). Else bounded count decrements per run edge; reaching 0 → HALTED, cause DONE. STOP takes priority over BP, BP over DONE, when simultaneous.
- cycle_count increments on every edge with `cpu_run` high.
- Output monitor: each cycle compares `out_port` to previous sample; on difference, next cycle `out_valid`=1, `out_data`=new value; sample always updated. Active in all states.

## Timing
- Command to `cpu_run` high: 1 cycle (state registered on accept edge).
- STEP: exactly one `cpu_run` cycle; HALTED the following cycle.
- RUN_N k: exactly k `cpu_run` cycles absent breakpoint/STOP.
- Breakpoint: `cpu_run` low in the same cycle `pc` matches; HALTED next edge.
- RESET command: `cpu_reset` high for RESET_CYCLES cycles starting the cycle after accept.
- `out_valid`: 1-cycle latency from `out_port` change; back-to-back changes give back-to-back pulses.
- `reset` mid-run: `cpu_reset` and `cpu_run`=0 immediately (same cycle `cpu_reset`, next cycle state), full reset sequence follows.

## Structure
- Package `overture_ctrl_pkg`: `cmd_op_t`, `ctrl_state_t`, `halt_cause_t` enums and opcode constants.
- Sub-module `overture_out_monitor`: change detector producing `out_valid`/`out_data`.

## Test plan
- Reset release → `cpu_reset` high 2 cycles after reset drops, `state` HALTED, `cmd_ready` 1, cause NONE.
- STEP three times with halting between → exactly 3 `cpu_run` cycles, `cycle_count`=3, cause DONE.
- RUN_N 5 then RUN_N 0 → 5 run cycles, cause DONE; second command stays HALTED, cause DONE, count unchanged.
- SET_BP addr 4 en, RUN from pc 0 → halts with pc=4, cause BP, `cpu_run` never high while pc=4; RUN again → executes pc 4, continues.
- RUN, STOP after 10 cycles concurrent with bp match → cause STOP; RESET → count 0, `cpu_reset` 2 cycles.
- `out_port` 0→7→7→9 → `out_valid` pulses with 7, then 9, none on repeat.

Source files
------------

// File: rtl/overture_ctrl_pkg.sv
// Shared types for the overture execution controller: command opcodes,
// controller states and halt causes.
package overture_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_RESET  = 3'd1,
    OP_RUN    = 3'd2,
    OP_STEP   = 3'd3,
    OP_RUN_N  = 3'd4,
    OP_STOP   = 3'd5,
    OP_SET_BP = 3'd6
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_CPU_RST = 2'd0,
    ST_HALTED  = 2'd1,
    ST_RUNNING = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_STOP = 2'd1,
    CAUSE_BP   = 2'd2,
    CAUSE_DONE = 2'd3
  } halt_cause_t;

  localparam int BP_ADDR_W  = 8;
  localparam int BP_EN_BIT  = 8;

endpackage

// File: rtl/overture_out_monitor.sv
// Change detector on the CPU output port: one-cycle pulse carrying the new
// value whenever the port differs from its previous sample.
module overture_out_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] out_port,
  output logic       out_valid,
  output logic [7:0] out_data
);

  logic [7:0] prev_sample;
  logic       changed;

  assign changed = (out_port != prev_sample);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sample <= 8'd0;
      out_valid   <= 1'b0;
      out_data    <= 8'd0;
    end else begin
      prev_sample <= out_port;
      out_valid   <= changed;
      if (changed) begin
        out_data <= out_port;
      end
    end
  end

endmodule

// File: rtl/overture_run_ctrl.sv
// Execution controller for overture_cpu: sequences cpu_reset/cpu_run from a
// command interface with free-run, step, run-for-N, stop and one PC breakpoint.
module overture_run_ctrl
  import overture_ctrl_pkg::*;
#(
  parameter int CYCLE_W      = 16,
  parameter int RESET_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [CYCLE_W-1:0] cmd_arg,
  input  logic [7:0]         pc,
  input  logic [7:0]         out_port,
  output logic               cpu_reset,
  output logic               cpu_run,
  output logic [1:0]         state,
  output logic [1:0]         halt_cause,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               out_valid,
  output logic [7:0]         out_data
);

  localparam int RC_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RESET_CYCLES);

  ctrl_state_t            state_q, state_d;
  halt_cause_t            cause_q, cause_d;
  logic [RC_W-1:0]        rst_cnt_q, rst_cnt_d;
  logic [CYCLE_W-1:0]     remaining_q, remaining_d;
  logic                   unbounded_q, unbounded_d;
  logic                   first_q, first_d;
  logic                   bp_en_q, bp_en_d;
  logic [BP_ADDR_W-1:0]   bp_addr_q, bp_addr_d;
  logic [CYCLE_W-1:0]     cycle_q, cycle_d;

  cmd_op_t op;
  logic    accept;
  logic    bp_hit;
  logic    run_now;

  // first_q masks the breakpoint for one cycle so a resumed run executes it
  assign op      = cmd_op_t'(cmd_op);
  assign accept  = cmd_valid && cmd_ready;
  assign bp_hit  = bp_en_q && (pc == bp_addr_q) && !first_q;
  assign run_now = (state_q == ST_RUNNING) && !bp_hit && !reset;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    rst_cnt_d   = rst_cnt_q;
    remaining_d = remaining_q;
    unbounded_d = unbounded_q;
    first_d     = first_q;
    bp_en_d     = bp_en_q;
    bp_addr_d   = bp_addr_q;
    cycle_d     = run_now ? cycle_q + CYCLE_W'(1) : cycle_q;

    if (accept && op == OP_SET_BP) begin
      bp_addr_d = cmd_arg[BP_ADDR_W-1:0];
      bp_en_d   = cmd_arg[BP_EN_BIT];
    end

    case (state_q)
      ST_CPU_RST: begin
        rst_cnt_d = rst_cnt_q - RC_W'(1);
        if (rst_cnt_q <= RC_W'(1)) begin
          state_d = ST_HALTED;
        end
      end

      ST_HALTED: begin
        if (accept) begin
          case (op)
            OP_RESET: begin
              state_d   = ST_CPU_RST;
              rst_cnt_d = RC_INIT;
              cycle_d   = '0;
              cause_d   = CAUSE_NONE;
            end
            OP_RUN: begin
              state_d     = ST_RUNNING;
              unbounded_d = 1'b1;
              first_d     = 1'b1;
            end
            OP_STEP: begin
              state_d     = ST_RUNNING;
              unbounded_d = 1'b0;
              remaining_d = CYCLE_W'(1);
              first_d     = 1'b1;
            end
            OP_RUN_N: begin
              if (cmd_arg == '0) begin
                cause_d = CAUSE_DONE;
              end else begin
                state_d     = ST_RUNNING;
                unbounded_d = 1'b0;
                remaining_d = cmd_arg;
                first_d     = 1'b1;
              end
            end
            OP_STOP: cause_d = CAUSE_STOP;
            default: ;
          endcase
        end
      end

      ST_RUNNING: begin
        first_d = 1'b0;
        // RESET, then STOP, then breakpoint, then bounded-count exhaustion
        if (accept && op == OP_RESET) begin
          state_d   = ST_CPU_RST;
          rst_cnt_d = RC_INIT;
          cycle_d   = '0;
          cause_d   = CAUSE_NONE;
        end else if (accept && op == OP_STOP) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_STOP;
        end else if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else if (!unbounded_q) begin
          remaining_d = remaining_q - CYCLE_W'(1);
          if (remaining_q <= CYCLE_W'(1)) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_DONE;
          end
        end
      end

      default: begin
        state_d   = ST_CPU_RST;
        rst_cnt_d = RC_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CPU_RST;
      cause_q     <= CAUSE_NONE;
      rst_cnt_q   <= RC_INIT;
      remaining_q <= '0;
      unbounded_q <= 1'b0;
      first_q     <= 1'b0;
      bp_en_q     <= 1'b0;
      bp_addr_q   <= '0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      rst_cnt_q   <= rst_cnt_d;
      remaining_q <= remaining_d;
      unbounded_q <= unbounded_d;
      first_q     <= first_d;
      bp_en_q     <= bp_en_d;
      bp_addr_q   <= bp_addr_d;
      cycle_q     <= cycle_d;
    end
  end

  assign cmd_ready   = (state_q != ST_CPU_RST);
  assign cpu_reset   = reset || (state_q == ST_CPU_RST);
  assign cpu_run     = run_now;
  assign state       = state_q;
  assign halt_cause  = cause_q;
  assign cycle_count = cycle_q;

  overture_out_monitor u_out_monitor (
    .clk       (clk),
    .reset     (reset),
    .out_port  (out_port),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_overture_run_ctrl.sv
// Scenario bench for overture_run_ctrl with a tiny CPU pc model and queue
// scoreboards for run lengths, halt causes and output-port pulses.
module tb_overture_run_ctrl;
  import overture_ctrl_pkg::*;

  localparam int CYCLE_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [2:0]         cmd_op = 3'd0;
  logic [CYCLE_W-1:0] cmd_arg = '0;
  logic [7:0]         pc;
  logic [7:0]         out_port = 8'd0;
  logic               cpu_reset, cpu_run;
  logic [1:0]         state, halt_cause;
  logic [CYCLE_W-1:0] cycle_count;
  logic               out_valid;
  logic [7:0]         out_data;

  int vectors = 0;
  int miscompares = 0;
  int run_seen = 0;
  int run_at_pc4 = 0;

  int          exp_runs_q[$];
  halt_cause_t exp_cause_q[$];
  logic [7:0]  exp_out_q[$];

  overture_run_ctrl #(.CYCLE_W(CYCLE_W), .RESET_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc), .out_port(out_port),
    .cpu_reset(cpu_reset), .cpu_run(cpu_run), .state(state),
    .halt_cause(halt_cause), .cycle_count(cycle_count),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // CPU stand-in: pc clears under reset, advances once per run edge
  always @(posedge clk) begin
    if (cpu_reset) pc <= 8'd0;
    else if (cpu_run) pc <= pc + 8'd1;
  end

  always @(negedge clk) begin
    if (cpu_run === 1'b1) run_seen++;
    if (cpu_run === 1'b1 && pc == 8'd4) run_at_pc4++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_cmd(input cmd_op_t op, input logic [CYCLE_W-1:0] arg);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    while (cmd_ready !== 1'b1) begin
      if (n == 20) begin
        $display("[TB] FAIL cmd_accept: cmd_ready=%b required 1 (op %0d)", cmd_ready, op);
        $fatal(1, "[TB] command never accepted");
      end
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = '0;
  endtask

  task automatic wait_halted();
    int n;
    n = 0;
    while (state !== 2'd1) begin
      if (n == 400) begin
        $display("[TB] FAIL wait_halted: state=%0d required 1", state);
        $fatal(1, "[TB] controller never halted");
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] seen;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_cpu_reset: got %b required 1", cpu_reset); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cmd_ready: got %b required 0", cmd_ready); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen[i] = cpu_reset;
    end
    vectors++; if (seen !== 4'b0011) begin miscompares++; $display("[TB] FAIL rst_release_seq: got %b required 0011", seen); end
    vectors++; if (state !== 2'd1) begin miscompares++; $display("[TB] FAIL rst_state: got %0d required 1", state); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_ready: got %b required 1", cmd_ready); end
    vectors++; if (halt_cause !== 2'd0) begin miscompares++; $display("[TB] FAIL rst_cause: got %0d required 0", halt_cause); end
    vectors++; if (cycle_count !== 16'd0 || out_valid !== 1'b0 || cpu_run !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_outputs: got cnt=%0d ov=%b run=%b required 0 0 0", cycle_count, out_valid, cpu_run); end
    @(posedge clk); #1;
  endtask

  task automatic test_step();
    int base, er;
    halt_cause_t ec;
    for (int i = 0; i < 3; i++) begin
      base = run_seen;
      exp_runs_q.push_back(1);
      exp_cause_q.push_back(CAUSE_DONE);
      send_cmd(OP_STEP, '0);
      vectors++; if (state !== 2'd2 || cpu_run !== 1'b1) begin miscompares++; $display("[TB] FAIL step_start: got state=%0d run=%b required 2 1", state, cpu_run); end
      wait_halted();
      er = exp_runs_q.pop_front();
      ec = exp_cause_q.pop_front();
      vectors++; if (run_seen - base != er) begin miscompares++; $display("[TB] FAIL step_runs: got %0d required %0d", run_seen - base, er); end
      vectors++; if (halt_cause !== ec) begin miscompares++; $display("[TB] FAIL step_cause: got %0d required %0d", halt_cause, ec); end
    end
    vectors++; if (cycle_count !== 16'd3) begin miscompares++; $display("[TB] FAIL step_count: got %0d required 3", cycle_count); end
  endtask

  task automatic test_run_n();
    int base, er;
    halt_cause_t ec;
    base = run_seen;
    exp_runs_q.push_back(5);
    exp_cause_q.push_back(CAUSE_DONE);
    send_cmd(OP_RUN_N, 16'd5);
    wait_halted();
    er = exp_runs_q.pop_front();
    ec = exp_cause_q.pop_front();
    vectors++; if (run_seen - base != er) begin miscompares++; $display("[TB] FAIL runn_runs: got %0d required %0d", run_seen - base, er); end
    vectors++; if (halt_cause !== ec) begin miscompares++; $display("[TB] FAIL runn_cause: got %0d required %0d", halt_cause, ec); end
    vectors++; if (cycle_count !== 16'd8) begin miscompares++; $display("[TB] FAIL runn_count: got %0d required 8", cycle_count); end
    send_cmd(OP_STOP, '0);
    vectors++; if (halt_cause !== 2'd1 || state !== 2'd1) begin miscompares++; $display("[TB] FAIL halted_stop: got cause=%0d state=%0d required 1 1", halt_cause, state); end
    base = run_seen;
    send_cmd(OP_RUN_N, 16'd0);
    vectors++; if (state !== 2'd1 || halt_cause !== 2'd3) begin miscompares++; $display("[TB] FAIL runn_zero: got state=%0d cause=%0d required 1 3", state, halt_cause); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (run_seen != base || cycle_count !== 16'd8) begin miscompares++; $display("[TB] FAIL runn_zero_idle: got runs=%0d cnt=%0d required 0 8", run_seen - base, cycle_count); end
  endtask

  task automatic test_breakpoint();
    int base, b4, er;
    halt_cause_t ec;
    send_cmd(OP_RESET, '0);
    wait_halted();
    vectors++; if (cycle_count !== 16'd0 || pc !== 8'd0) begin miscompares++; $display("[TB] FAIL bp_prep: got cnt=%0d pc=%0d required 0 0", cycle_count, pc); end
    send_cmd(OP_SET_BP, 16'h0104);
    base = run_seen;
    b4   = run_at_pc4;
    exp_runs_q.push_back(4);
    exp_cause_q.push_back(CAUSE_BP);
    send_cmd(OP_RUN, '0);
    wait_halted();
    er = exp_runs_q.pop_front();
    ec = exp_cause_q.pop_front();
    vectors++; if (run_seen - base != er) begin miscompares++; $display("[TB] FAIL bp_runs: got %0d required %0d", run_seen - base, er); end
    vectors++; if (halt_cause !== ec) begin miscompares++; $display("[TB] FAIL bp_cause: got %0d required %0d", halt_cause, ec); end
    vectors++; if (pc !== 8'd4 || run_at_pc4 != b4) begin miscompares++; $display("[TB] FAIL bp_pc: got pc=%0d runs_at_bp=%0d required 4 0", pc, run_at_pc4 - b4); end
    b4 = run_at_pc4;
    send_cmd(OP_RUN, '0);
    vectors++; if (cpu_run !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_resume_run: got %b required 1", cpu_run); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (pc !== 8'd7 || state !== 2'd2 || run_at_pc4 - b4 != 1) begin miscompares++; $display("[TB] FAIL bp_resume: got pc=%0d state=%0d runs_at_bp=%0d required 7 2 1", pc, state, run_at_pc4 - b4); end
  endtask

  task automatic test_stop_and_reset();
    int base, er;
    halt_cause_t ec;
    logic [2:0] seen;
    send_cmd(OP_STOP, '0);
    vectors++; if (state !== 2'd1 || halt_cause !== 2'd1) begin miscompares++; $display("[TB] FAIL run_stop: got state=%0d cause=%0d required 1 1", state, halt_cause); end
    send_cmd(OP_RESET, '0);
    wait_halted();
    send_cmd(OP_SET_BP, 16'h010A);
    base = run_seen;
    exp_runs_q.push_back(10);
    exp_cause_q.push_back(CAUSE_STOP);
    send_cmd(OP_RUN, '0);
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (pc !== 8'd10 || cpu_run !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_bp_align: got pc=%0d run=%b required 10 0", pc, cpu_run); end
    send_cmd(OP_STOP, '0);
    er = exp_runs_q.pop_front();
    ec = exp_cause_q.pop_front();
    vectors++; if (run_seen - base != er) begin miscompares++; $display("[TB] FAIL stop_runs: got %0d required %0d", run_seen - base, er); end
    vectors++; if (halt_cause !== ec || state !== 2'd1) begin miscompares++; $display("[TB] FAIL stop_prio: got cause=%0d state=%0d required %0d 1", halt_cause, state, ec); end
    vectors++; if (cycle_count !== 16'd10) begin miscompares++; $display("[TB] FAIL stop_count: got %0d required 10", cycle_count); end
    send_cmd(OP_RESET, '0);
    vectors++; if (cycle_count !== 16'd0 || halt_cause !== 2'd0) begin miscompares++; $display("[TB] FAIL resetcmd_clear: got cnt=%0d cause=%0d required 0 0", cycle_count, halt_cause); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen[i] = cpu_reset;
    end
    vectors++; if (seen !== 3'b011) begin miscompares++; $display("[TB] FAIL resetcmd_seq: got %b required 011", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_monitor();
    logic [7:0] vals [6];
    logic [7:0] prev, exp;
    int pulses;
    vals[0] = 8'd7; vals[1] = 8'd7; vals[2] = 8'd9;
    vals[3] = 8'd3; vals[4] = 8'd5; vals[5] = 8'd5;
    prev   = 8'd0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        out_port = vals[i];
        if (vals[i] != prev) exp_out_q.push_back(vals[i]);
        prev = vals[i];
      end
      @(negedge clk);
      if (out_valid === 1'b1) begin
        pulses++;
        vectors++;
        if (exp_out_q.size() == 0) begin
          miscompares++; $display("[TB] FAIL out_unexpected: got data=%0d required no pulse", out_data);
        end else begin
          exp = exp_out_q.pop_front();
          if (out_data !== exp) begin miscompares++; $display("[TB] FAIL out_data: got %0d required %0d", out_data, exp); end
        end
      end
      @(posedge clk); #1;
    end
    vectors++; if (pulses != 4 || exp_out_q.size() != 0) begin miscompares++; $display("[TB] FAIL out_pulses: got %0d pulses (%0d unmatched) required 4 (0)", pulses, exp_out_q.size()); end
  endtask

  task automatic test_reset_midrun();
    send_cmd(OP_RUN, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("[TB] FAIL midrun_cpu_reset: got %b required 1", cpu_reset); end
    @(posedge clk); #1;
    vectors++; if (state !== 2'd0 || cpu_run !== 1'b0 || cycle_count !== 16'd0) begin miscompares++; $display("[TB] FAIL midrun_state: got state=%0d run=%b cnt=%0d required 0 0 0", state, cpu_run, cycle_count); end
    reset = 1'b0;
    wait_halted();
    vectors++; if (cmd_ready !== 1'b1 || halt_cause !== 2'd0) begin miscompares++; $display("[TB] FAIL midrun_recover: got ready=%b cause=%0d required 1 0", cmd_ready, halt_cause); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_n();
    test_breakpoint();
    test_stop_and_reset();
    test_out_monitor();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
